// File: rtl/serial_deserializer.sv
// rtl/serial_deserializer.sv - serial-to-parallel word assembler with one-entry output buffer
module serial_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             dir,
  input  logic             frame,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             dir_q;
  logic             word_start;
  logic             word_dir;
  logic             complete;
  logic             accept_word;
  logic             drop_word;

  // Direction is taken live on the first bit of a word (or a frame restart),
  // otherwise from the latched copy so mid-word dir changes are ignored.
  always_comb begin
    word_start  = frame || (bit_cnt == '0);
    word_dir    = word_start ? dir : dir_q;
    sr_next     = word_dir ? {sin, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], sin};
    complete    = sin_valid && !frame && (bit_cnt == LAST_BIT);
    accept_word = complete && (!dout_valid || dout_ready);
    drop_word   = complete && dout_valid && !dout_ready;
  end

  // Shift register, bit counter and per-word direction latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
      dir_q   <= 1'b0;
    end else begin
      if (sin_valid) begin
        sr <= sr_next;
        if (word_start) begin
          dir_q <= dir;
        end
      end
      if (frame) begin
        bit_cnt <= sin_valid ? CNT_W'(1) : '0;
      end else if (sin_valid) begin
        bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
      end
    end
  end

  // One-entry output buffer; a completed word is dropped only when the
  // buffer is full and not being drained on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (accept_word) begin
      dout       <= sr_next;
      dout_valid <= 1'b1;
    end else if (dout_valid && dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  // Sticky overrun; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (drop_word) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// tb/tb_serial_deserializer.sv - scoreboard bench for serial_deserializer
module tb_serial_deserializer;

  logic       clk;
  logic       rst_n;
  logic       sin;
  logic       sin_valid;
  logic       dir;
  logic       frame;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic [3:0] bit_cnt;
  logic       overrun;
  logic       ovr_clr;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];

  serial_deserializer #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .sin_valid(sin_valid), .dir(dir),
    .frame(frame), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .bit_cnt(bit_cnt), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b, input logic d, input logic fr);
    sin       = b;
    dir       = d;
    frame     = fr;
    sin_valid = 1'b1;
    step();
    sin_valid = 1'b0;
    frame     = 1'b0;
  endtask

  // Streams one word; optional ovr_clr and dout_ready assertion on the last bit.
  task automatic send_word(input logic [7:0] w, input logic d, input bit push,
                           input bit clr_last, input bit rdy_last);
    for (int i = 0; i < 8; i++) begin
      ovr_clr = clr_last && (i == 7);
      if (rdy_last && i == 7) dout_ready = 1'b1;
      bit_in(d ? w[i] : w[7-i], d, 1'b0);
    end
    ovr_clr = 1'b0;
    if (push) sb.push_back(w);
  endtask

  // Monitor: every word handed to the consumer must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && dout_valid && dout_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %0h expected none", dout);
      end else begin
        check("word", {24'd0, dout}, {24'd0, sb.pop_front()});
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Directed stimulus.
  initial begin
    logic [7:0] w;
    rst_n = 1'b0; sin = 1'b0; sin_valid = 1'b0; dir = 1'b0; frame = 1'b0;
    dout_ready = 1'b0; ovr_clr = 1'b0;
    step();
    check("rst_dout", {24'd0, dout}, 32'h0);
    check("rst_valid", {31'd0, dout_valid}, 32'h0);
    check("rst_bitcnt", {28'd0, bit_cnt}, 32'h0);
    check("rst_overrun", {31'd0, overrun}, 32'h0);
    rst_n = 1'b1;
    dout_ready = 1'b1;
    step();

    // MSB-first A5, latency check
    w = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      bit_in(w[7-i], 1'b0, 1'b0);
      if (i == 6) begin
        check("msb_cnt7", {28'd0, bit_cnt}, 32'd7);
        check("msb_notyet", {31'd0, dout_valid}, 32'h0);
      end
    end
    sb.push_back(8'hA5);
    check("msb_dout", {24'd0, dout}, 32'hA5);
    check("msb_valid", {31'd0, dout_valid}, 32'h1);
    check("msb_cnt0", {28'd0, bit_cnt}, 32'h0);
    step();

    // LSB-first 3C with a gap and a mid-word dir toggle
    w = 8'h3C;
    for (int i = 0; i < 4; i++) bit_in(w[i], 1'b1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      step();
      check("gap_cnt", {28'd0, bit_cnt}, 32'd4);
    end
    for (int i = 4; i < 8; i++) bit_in(w[i], 1'b0, 1'b0);
    sb.push_back(8'h3C);
    check("lsb_dout", {24'd0, dout}, 32'h3C);
    step();

    // Overrun
    dout_ready = 1'b0;
    send_word(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_hold_dout", {24'd0, dout}, 32'h11);
    check("ovr_set", {31'd0, overrun}, 32'h1);
    send_word(8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_set_wins", {31'd0, overrun}, 32'h1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    check("ovr_cleared", {31'd0, overrun}, 32'h0);
    check("ovr_dout_still", {24'd0, dout}, 32'h11);

    // Accept and complete on the same edge
    send_word(8'h22, 1'b0, 1'b1, 1'b0, 1'b1);
    check("sim_dout", {24'd0, dout}, 32'h22);
    check("sim_valid", {31'd0, dout_valid}, 32'h1);
    check("sim_overrun", {31'd0, overrun}, 32'h0);
    step();

    // Frame realignment after 5 bits
    for (int i = 0; i < 5; i++) bit_in(1'b1, 1'b0, 1'b0);
    w = 8'h96;
    bit_in(w[7], 1'b0, 1'b1);
    check("frame_cnt1", {28'd0, bit_cnt}, 32'd1);
    for (int i = 6; i >= 0; i--) bit_in(w[i], 1'b0, 1'b0);
    sb.push_back(8'h96);
    check("frame_cnt0", {28'd0, bit_cnt}, 32'd0);
    step();

    // Frame at bit_cnt==7 emits nothing
    for (int i = 0; i < 7; i++) bit_in(1'b0, 1'b0, 1'b0);
    check("frame7_cnt", {28'd0, bit_cnt}, 32'd7);
    w = 8'hC3;
    bit_in(w[7], 1'b0, 1'b1);
    check("frame7_restart", {28'd0, bit_cnt}, 32'd1);
    check("frame7_novalid", {31'd0, dout_valid}, 32'h0);
    for (int i = 6; i >= 0; i--) bit_in(w[i], 1'b0, 1'b0);
    sb.push_back(8'hC3);
    step();

    // Asynchronous reset mid-word with a buffered word and overrun set
    dout_ready = 1'b0;
    send_word(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) bit_in(1'b1, 1'b0, 1'b0);
    check("pre_rst_valid", {31'd0, dout_valid}, 32'h1);
    check("pre_rst_ovr", {31'd0, overrun}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dout", {24'd0, dout}, 32'h0);
    check("arst_valid", {31'd0, dout_valid}, 32'h0);
    check("arst_cnt", {28'd0, bit_cnt}, 32'h0);
    check("arst_ovr", {31'd0, overrun}, 32'h0);
    step();
    rst_n = 1'b1;
    dout_ready = 1'b1;
    step();
    send_word(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
    check("post_rst_dout", {24'd0, dout}, 32'hFF);
    check("post_rst_valid", {31'd0, dout_valid}, 32'h1);

    step();
    step();
    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
